// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern generator: FSM state
// encoding, LFSR tap placement and the default seed.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  // Second feedback tap sits this many bits below the MSB (x^33 + x^20 + 1 for N=16).
  localparam int unsigned TAP_OFFSET = 13;

  localparam int unsigned DEFAULT_N = 16;
  localparam logic [2*DEFAULT_N:0] DEFAULT_SEED = {{(2*DEFAULT_N){1'b0}}, 1'b1};

  function automatic int unsigned tap_hi(input int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned tap_lo(input int unsigned width);
    return width - 1 - TAP_OFFSET;
  endfunction

endpackage

// File: rtl/bist_pattern_gen_if.sv
// Handshake and pattern bus between the test controller / adder mux and the
// BIST pattern generator. seed_in exists only when BIST_SEED_LOAD_EN is defined.
interface bist_pattern_gen_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 11
);

  logic          start;
  logic          abort;
`ifdef BIST_SEED_LOAD_EN
  logic [2*N:0]  seed_in;
`endif
  logic [N-1:0]  bist_a;
  logic [N-1:0]  bist_b;
  logic          bist_cin;
  logic          bist_sel;
  logic          pattern_valid;
  logic [CW-1:0] pattern_idx;
  logic          busy;
  logic          done;

`ifdef BIST_SEED_LOAD_EN
  modport master (
    output start, abort, seed_in,
    input  bist_a, bist_b, bist_cin, bist_sel, pattern_valid, pattern_idx, busy, done
  );
  modport slave (
    input  start, abort, seed_in,
    output bist_a, bist_b, bist_cin, bist_sel, pattern_valid, pattern_idx, busy, done
  );
`else
  modport master (
    output start, abort,
    input  bist_a, bist_b, bist_cin, bist_sel, pattern_valid, pattern_idx, busy, done
  );
  modport slave (
    input  start, abort,
    output bist_a, bist_b, bist_cin, bist_sel, pattern_valid, pattern_idx, busy, done
  );
`endif

endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR with synchronous load and enable. A zero load value is
// replaced by SEED so the register can never lock up at all-zeros.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned   W    = 33,
  parameter logic [W-1:0]  SEED = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] lfsr_nxt
);

  localparam int unsigned TAP_HI = tap_hi(W);
  localparam int unsigned TAP_LO = tap_lo(W);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic [W-1:0] seed_s;

  // Next-state: load wins over shift; the next value is exported so the
  // parent can register its outputs in the same cycle the LFSR updates.
  always_comb begin
    seed_s = (load_val == {W{1'b0}}) ? SEED : load_val;
    if (load) begin
      lfsr_d = seed_s;
    end else if (en) begin
      lfsr_d = {lfsr_q[W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_nxt = lfsr_d;

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus source for the ripple adder: LFSR operand pairs, mux select
// and start/abort/done handshake. Optional seed input under BIST_SEED_LOAD_EN.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int unsigned  N            = 16,
  parameter int unsigned  NUM_PATTERNS = 1024,
  parameter logic [2*N:0] SEED         = (2*N+1)'(DEFAULT_SEED)
) (
  input logic               clk,
  input logic               rst_n,
  bist_pattern_gen_if.slave bus
);

  localparam int unsigned   CW       = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PATTERNS - 1);

  bist_state_e   state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] idx_q, idx_d;

  logic          lfsr_load_s;
  logic          lfsr_en_s;
  logic [2*N:0]  seed_s;
  logic [2*N:0]  lfsr_nxt_s;

`ifdef BIST_SEED_LOAD_EN
  assign seed_s = bus.seed_in;
`else
  assign seed_s = SEED;
`endif

  bist_lfsr #(
    .W    (2*N + 1),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load_s),
    .en       (lfsr_en_s),
    .load_val (seed_s),
    .lfsr_nxt (lfsr_nxt_s)
  );

  // FSM next-state, counter and output next-values; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    lfsr_load_s = 1'b0;
    lfsr_en_s   = 1'b0;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          lfsr_load_s = 1'b1;
          idx_d       = {CW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          lfsr_en_s = 1'b1;
          idx_d     = idx_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d     = IDLE;
      lfsr_load_s = 1'b0;
      lfsr_en_s   = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Operands track the LFSR value being loaded/shifted this edge; DONE holds them.
    if (state_d == IDLE) begin
      a_d   = {N{1'b0}};
      b_d   = {N{1'b0}};
      cin_d = 1'b0;
      idx_d = {CW{1'b0}};
    end else if (lfsr_load_s || lfsr_en_s) begin
      a_d   = lfsr_nxt_s[2*N:N+1];
      b_d   = lfsr_nxt_s[N:1];
      cin_d = lfsr_nxt_s[0];
    end else begin
      a_d = a_q;
    end

    sel_d   = (state_d == RUN);
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      cin_q   <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.bist_a        = a_q;
  assign bus.bist_b        = b_q;
  assign bus.bist_cin      = cin_q;
  assign bus.bist_sel      = sel_q;
  assign bus.pattern_valid = valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pattern_idx   = idx_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Self-checking bench for bist_pattern_gen: a short-run instance (4 patterns)
// driven from a vector table, and a 40-pattern instance for the LFSR sequence.
module tb_bist_pattern_gen;

  localparam int N   = 16;
  localparam int NP1 = 4;
  localparam int CW1 = $clog2(NP1 + 1);
  localparam int NP2 = 40;
  localparam int CW2 = $clog2(NP2 + 1);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sel;
    logic        valid;
    logic        busy;
    logic        done;
    logic [7:0]  idx;
  } exp_t;

  typedef struct {
    bit start;
    bit abort;
    int pat;
    bit run;
    bit dn;
    int idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [32:0] ref_pat [0:NP2];
  exp_t        sb [$];
  vec_t        tbl [$];

  always #5 clk = ~clk;

  bist_pattern_gen_if #(.N(N), .CW(CW1)) bus1 ();
  bist_pattern_gen_if #(.N(N), .CW(CW2)) bus2 ();

  bist_pattern_gen #(.N(N), .NUM_PATTERNS(NP1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  bist_pattern_gen #(.N(N), .NUM_PATTERNS(NP2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic [32:0] lfsr_step(input logic [32:0] v);
    return {v[31:0], v[32] ^ v[19]};
  endfunction

  function automatic exp_t mk(input int pat, input bit run, input bit dn, input int idx);
    exp_t e;
    logic [32:0] v;
    v = (pat < 0) ? 33'd0 : ref_pat[pat];
    e.a     = v[32:17];
    e.b     = v[16:1];
    e.cin   = v[0];
    e.sel   = run;
    e.valid = run;
    e.busy  = run;
    e.done  = dn;
    e.idx   = 8'(idx);
    return e;
  endfunction

  function automatic exp_t got(input bit which);
    exp_t g;
    if (which) begin
      g = {bus2.bist_a, bus2.bist_b, bus2.bist_cin, bus2.bist_sel, bus2.pattern_valid,
           bus2.busy, bus2.done, 8'(bus2.pattern_idx)};
    end else begin
      g = {bus1.bist_a, bus1.bist_b, bus1.bist_cin, bus1.bist_sel, bus1.pattern_valid,
           bus1.busy, bus1.done, 8'(bus1.pattern_idx)};
    end
    return g;
  endfunction

  task automatic check(input string name, input exp_t g);
    exp_t w;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      w = sb.pop_front();
      if (g !== w) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h cin=%b sel=%b val=%b busy=%b done=%b idx=%0d want a=%h b=%h cin=%b sel=%b val=%b busy=%b done=%b idx=%0d",
                 name, g.a, g.b, g.cin, g.sel, g.valid, g.busy, g.done, g.idx,
                 w.a, w.b, w.cin, w.sel, w.valid, w.busy, w.done, w.idx);
      end
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] g, input logic [31:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, g, w);
    end
  endtask

  task automatic step(input bit which, input bit s, input bit ab, input exp_t e, input string name);
    @(negedge clk);
    if (which) begin
      bus2.start = s;
      bus2.abort = ab;
    end else begin
      bus1.start = s;
      bus1.abort = ab;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name, got(which));
  endtask

  initial begin
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus2.start = 1'b0;
    bus2.abort = 1'b0;
`ifdef BIST_SEED_LOAD_EN
    bus1.seed_in = 33'd0;
    bus2.seed_in = 33'd0;
`endif
    ref_pat[0] = 33'd1;
    for (int k = 1; k <= NP2; k++) ref_pat[k] = lfsr_step(ref_pat[k-1]);

    // Reset state
    #12;
    sb.push_back(mk(-1, 1'b0, 1'b0, 0));
    check("reset_outputs", got(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // First patterns from the default seed against literal values
    step(1'b0, 1'b1, 1'b0, mk(0, 1'b1, 1'b0, 0), "first_p0");
    chk_val("p0_a", 32'(bus1.bist_a), 32'h0000);
    chk_val("p0_b", 32'(bus1.bist_b), 32'h0000);
    chk_val("p0_cin", 32'(bus1.bist_cin), 32'h1);
    step(1'b0, 1'b0, 1'b0, mk(1, 1'b1, 1'b0, 1), "first_p1");
    chk_val("p1_b", 32'(bus1.bist_b), 32'h0001);
    chk_val("p1_cin", 32'(bus1.bist_cin), 32'h0);

    // Async reset mid-RUN clears outputs without a clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(-1, 1'b0, 1'b0, 0));
    check("async_reset_midrun", got(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, mk(-1, 1'b0, 1'b0, 0), "post_reset_idle");

    // Vector table: run, done hold, restart, abort+start, abort in IDLE/DONE
    tbl.push_back('{1'b1, 1'b0,  0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0,  1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0,  2, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b0,  3, 1'b1, 1'b0, 3});
    for (int i = 0; i < 11; i++) tbl.push_back('{1'b0, 1'b0, 3, 1'b0, 1'b1, 3});
    tbl.push_back('{1'b1, 1'b0,  0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0,  1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  2, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b1, -1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, -1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, -1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0,  0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0,  1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 1'b0,  2, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b0, 1'b0,  3, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0,  3, 1'b0, 1'b1, 3});
    tbl.push_back('{1'b0, 1'b1, -1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, -1, 1'b0, 1'b0, 0});
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].start, tbl[i].abort,
           mk(tbl[i].pat, tbl[i].run, tbl[i].dn, tbl[i].idx), $sformatf("vec%0d", i));
    end

    // Long run: LFSR sequence across both feedback taps
    step(1'b1, 1'b1, 1'b0, mk(0, 1'b1, 1'b0, 0), "long_p0");
    for (int k = 1; k < NP2; k++) begin
      step(1'b1, 1'b0, 1'b0, mk(k, 1'b1, 1'b0, k), $sformatf("long_p%0d", k));
    end
    step(1'b1, 1'b0, 1'b0, mk(NP2-1, 1'b0, 1'b1, NP2-1), "long_done");

`ifdef BIST_SEED_LOAD_EN
    begin
      exp_t e;
      bus1.seed_in = 33'd0;
      step(1'b0, 1'b1, 1'b0, mk(0, 1'b1, 1'b0, 0), "seed_zero_fallback");
      step(1'b0, 1'b0, 1'b1, mk(-1, 1'b0, 1'b0, 0), "seed_abort");
      bus1.seed_in = 33'h1_0000_0000;
      e = mk(-1, 1'b1, 1'b0, 0);
      e.a = 16'h8000;
      step(1'b0, 1'b1, 1'b0, e, "seed_msb");
      chk_val("seed_msb_a", 32'(bus1.bist_a), 32'h8000);
    end
`endif

    @(negedge clk);
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus2.start = 1'b0;
    bus2.abort = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
